// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked ALU: opcodes, FSM states and result width.
package alu_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_DONE} state_e;

  function automatic int RES_W(input int w);
    return 2 * w;
  endfunction
endpackage

// File: rtl/alu_seq_divider.sv
// Restoring divider resolving DIV_UNROLL quotient bits per cycle.
// last_o marks the cycle whose clock edge writes the final quotient/remainder.
module alu_seq_divider #(
  parameter int WIDTH      = 4,
  parameter int DIV_UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);
  localparam int STEPS = WIDTH / DIV_UNROLL;
  localparam int CW    = $clog2(STEPS + 1);

  logic             run_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] q_q, r_q, b_q, q_d, r_d;
  logic [WIDTH:0]   trial;

  // Dividend bits shift out of the top of q while quotient bits enter at the bottom.
  always_comb begin
    q_d   = q_q;
    r_d   = r_q;
    trial = '0;
    for (int i = 0; i < DIV_UNROLL; i++) begin
      trial = {r_d, q_d[WIDTH-1]};
      q_d   = q_d << 1;
      if (trial >= {1'b0, b_q}) begin
        trial  = trial - {1'b0, b_q};
        q_d[0] = 1'b1;
      end
      r_d = trial[WIDTH-1:0];
    end
  end

  assign last_o = run_q && (cnt_q == CW'(STEPS - 1));
  assign quo_o  = q_q;
  assign rem_o  = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
      b_q   <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      q_q   <= a_i;
      r_q   <= '0;
      b_q   <= b_i;
    end else if (run_q) begin
      q_q   <= q_d;
      r_q   <= r_d;
      cnt_q <= cnt_q + 1'b1;
      if (last_o) run_q <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_pipe_ctrl.sv
// Registered valid/ready ALU: single-cycle op mux, iterative divider, output register
// that holds its contents under back-pressure.
module alu_pipe_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DIV_UNROLL = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        A,
  input  logic [WIDTH-1:0]        B,
  input  logic                    Cin,
  input  logic                    full_adder,
  input  logic                    red_A,
  input  logic                    red_B,
  input  logic                    bypass_A,
  input  logic                    bypass_B,
  input  logic [2:0]              opcode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RES_W(WIDTH)-1:0] out,
  output logic                    odd_parity,
  output logic                    invalid,
  output logic                    busy
);
  localparam int RW = RES_W(WIDTH);

  state_e          state_q;
  logic [RW-1:0]   out_q, mux_res, div_res;
  logic            par_q, inv_q, vld_q, div_inv_q;
  logic            mux_par, mux_inv, arith;
  logic            accept, div_go, div_last, out_free;
  logic [WIDTH:0]  sum;
  logic [WIDTH-1:0] quo, rem;

  assign out_free = !vld_q || out_ready;
  assign in_ready = (state_q == ST_IDLE) && out_free;
  assign accept   = in_valid && in_ready;
  assign div_go   = accept && !bypass_A && !bypass_B && (opcode == OP_DIV) && (B != '0);
  assign sum      = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, full_adder & Cin};
  assign div_res  = {rem, quo};

  always_comb begin
    mux_res = '0;
    mux_inv = 1'b0;
    arith   = 1'b0;
    if (bypass_A)      mux_res = RW'(A);
    else if (bypass_B) mux_res = RW'(B);
    else begin
      case (opcode)
        OP_AND: mux_res = red_A ? RW'(&A) : red_B ? RW'(&B) : RW'(A & B);
        OP_XOR: mux_res = red_A ? RW'(^A) : red_B ? RW'(^B) : RW'(A ^ B);
        OP_OR:  mux_res = red_A ? RW'(|A) : red_B ? RW'(|B) : RW'(A | B);
        OP_ADD: begin mux_res = RW'(sum);           arith = 1'b1; mux_inv = red_A | red_B; end
        OP_MUL: begin mux_res = RW'(A) * RW'(B);    arith = 1'b1; mux_inv = red_A | red_B; end
        OP_SUB: begin
          mux_res = (A >= B) ? RW'(A - B) : RW'(B - A);
          arith   = 1'b1;
          mux_inv = red_A | red_B;
        end
        // Only reached for B==0; nonzero divisors go through the divider.
        OP_DIV: begin mux_res = RW'(A);             arith = 1'b1; mux_inv = 1'b1; end
        default: mux_inv = 1'b1;
      endcase
    end
    mux_par = arith & ~^mux_res;
  end

  alu_seq_divider #(.WIDTH(WIDTH), .DIV_UNROLL(DIV_UNROLL)) u_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_go),
    .a_i     (A),
    .b_i     (B),
    .last_o  (div_last),
    .quo_o   (quo),
    .rem_o   (rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      out_q     <= '0;
      par_q     <= 1'b0;
      inv_q     <= 1'b0;
      vld_q     <= 1'b0;
      div_inv_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (div_go) begin
          state_q   <= ST_DIV;
          div_inv_q <= red_A | red_B;
        end
        ST_DIV:  if (div_last) state_q <= ST_DONE;
        ST_DONE: if (out_free) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase

      if (state_q == ST_DONE && out_free) begin
        out_q <= div_res;
        par_q <= ~^div_res;
        inv_q <= div_inv_q;
        vld_q <= 1'b1;
      end else if (accept && !div_go) begin
        out_q <= mux_res;
        par_q <= mux_par;
        inv_q <= mux_inv;
        vld_q <= 1'b1;
      end else if (out_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign out        = out_q;
  assign odd_parity = par_q;
  assign invalid    = inv_q;
  assign out_valid  = vld_q;
  assign busy       = (state_q == ST_DIV);
endmodule

// File: tb/tb_alu_pipe_ctrl.sv
// Directed and randomized bench for alu_pipe_ctrl with a transaction-level scoreboard.
module tb_alu_pipe_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, Cin, full_adder, red_A, red_B, bypass_A, bypass_B;
  logic [3:0] A, B;
  logic [2:0] opcode;
  logic       out_valid, out_ready, odd_parity, invalid, busy;
  logic [7:0] out;

  int nvec = 0;
  int nbad = 0;
  logic [9:0] sb[$];
  logic       hold_prev = 1'b0;
  logic [9:0] prev = '0;

  always #5 clk = ~clk;

  alu_pipe_ctrl #(.WIDTH(4), .DIV_UNROLL(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .full_adder(full_adder),
    .red_A(red_A), .red_B(red_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
    .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .odd_parity(odd_parity), .invalid(invalid), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result {invalid, odd_parity, out} from the op rules, in plain integer arithmetic.
  function automatic logic [9:0] model(input logic [3:0] a, input logic [3:0] b,
      input logic cin, input logic fa, input logic ra, input logic rb,
      input logic ba, input logic bb, input logic [2:0] op);
    int r; bit inv, ar;
    r = 0; inv = 0; ar = 0;
    if (ba)      r = a;
    else if (bb) r = b;
    else case (op)
      3'd0: r = ra ? int'(a == 15) : rb ? int'(b == 15) : int'(a & b);
      3'd1: r = ra ? $countones(a) % 2 : rb ? $countones(b) % 2 : int'(a ^ b);
      3'd6: r = ra ? int'(a != 0) : rb ? int'(b != 0) : int'(a | b);
      3'd2: begin r = int'(a) + int'(b) + ((fa && cin) ? 1 : 0); ar = 1; inv = ra | rb; end
      3'd3: begin r = int'(a) * int'(b); ar = 1; inv = ra | rb; end
      3'd4: begin r = (a > b) ? int'(a) - int'(b) : int'(b) - int'(a); ar = 1; inv = ra | rb; end
      3'd5: begin
        ar = 1;
        if (b == 0) begin r = a; inv = 1; end
        else begin r = (int'(a) % int'(b)) * 16 + int'(a) / int'(b); inv = ra | rb; end
      end
      default: inv = 1;
    endcase
    return {inv, ar && ($countones(r) % 2 == 0), 8'(r)};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      hold_prev <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_has_entry", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) chk("result", {invalid, odd_parity, out}, sb.pop_front());
      end
      if (hold_prev) chk("hold", {out_valid, invalid, odd_parity, out}, {1'b1, prev});
      if (in_valid && in_ready)
        sb.push_back(model(A, B, Cin, full_adder, red_A, red_B, bypass_A, bypass_B, opcode));
      hold_prev <= out_valid && !out_ready;
      prev      <= {invalid, odd_parity, out};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
      input logic cin, input logic fa, input logic ra, input logic rb,
      input logic ba, input logic bb);
    in_valid = 1'b1; opcode = op; A = a; B = b; Cin = cin; full_adder = fa;
    red_A = ra; red_B = rb; bypass_A = ba; bypass_B = bb;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    drv(3'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    #1;
    chk("rst_out", out, 0);
    chk("rst_flags", {out_valid, odd_parity, invalid, busy}, 0);
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);

    // ADD with carry-in
    drv(3'd2, 4'hF, 4'hF, 1, 1, 0, 0, 0, 0);
    step(); in_valid = 1'b0;
    chk("add_out", out, 8'h1F);
    chk("add_flags", {out_valid, odd_parity, invalid}, 3'b100);

    // back-to-back AND then XOR
    drv(3'd0, 4'hC, 4'hA, 0, 0, 0, 0, 0, 0);
    step();
    chk("and_out", out, 8'h08);
    chk("b2b_in_ready", in_ready, 1);
    drv(3'd1, 4'hC, 4'hA, 0, 0, 0, 0, 0, 0);
    step(); in_valid = 1'b0;
    chk("xor_out", out, 8'h06);
    chk("xor_valid", out_valid, 1);

    // DIV 13/3: four busy cycles, result one cycle later
    drv(3'd5, 4'd13, 4'd3, 0, 0, 0, 0, 0, 0);
    step(); in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("div_busy", busy, 1);
      chk("div_in_ready", in_ready, 0);
      step();
    end
    chk("div_done_busy", {busy, out_valid}, 2'b00);
    step();
    chk("div_out", out, 8'h14);
    chk("div_flags", {out_valid, odd_parity, invalid}, 3'b110);

    // divide by zero, and MUL with reduction flag
    drv(3'd5, 4'd9, 4'd0, 0, 0, 0, 0, 0, 0);
    step();
    chk("div0_out", out, 8'h09);
    chk("div0_flags", {out_valid, invalid}, 2'b11);
    drv(3'd3, 4'd3, 4'd5, 0, 0, 1, 0, 0, 0);
    step(); in_valid = 1'b0;
    chk("mulred_out", out, 8'h0F);
    chk("mulred_flags", {out_valid, odd_parity, invalid}, 3'b111);

    // SUB under back-pressure
    drv(3'd4, 4'd2, 4'd7, 0, 0, 0, 0, 0, 0);
    step(); in_valid = 1'b0; out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("sub_held", {out_valid, out}, {1'b1, 8'h05});
      chk("sub_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("sub_release_rdy", in_ready, 1);
    step();
    chk("sub_popped", out_valid, 0);

    // reset in the second DIV cycle aborts the division
    drv(3'd5, 4'd13, 4'd3, 0, 0, 0, 0, 0, 0);
    step(); in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("abort_out", out, 0);
    chk("abort_flags", {out_valid, odd_parity, invalid, busy, in_ready}, 5'b00001);
    step(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_quiet", {out_valid, busy}, 0);
    end
    drv(3'd2, 4'd1, 4'd1, 0, 0, 0, 0, 0, 0);
    step(); in_valid = 1'b0;
    chk("post_rst_add", {out_valid, out}, {1'b1, 8'h02});

    // randomized traffic, checked by the scoreboard monitor
    repeat (600) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      opcode     = ($urandom_range(0, 3) == 0) ? 3'd5 : 3'($urandom_range(0, 7));
      A          = 4'($urandom);
      B          = 4'($urandom);
      Cin        = 1'($urandom);
      full_adder = 1'($urandom);
      red_A      = ($urandom_range(0, 7) == 0);
      red_B      = ($urandom_range(0, 7) == 0);
      bypass_A   = ($urandom_range(0, 15) == 0);
      bypass_B   = ($urandom_range(0, 15) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40 && (sb.size() != 0 || out_valid || busy); i++) step();
    chk("drain_empty", sb.size(), 0);
    chk("drain_idle", {out_valid, busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
